fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin write arbiter in front of a shared FIFO.
// Optional burst locking is compiled in with `define ARB_BURST_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NUM_BITS  = 32,
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_BITS-1:0]  req_data,
  input  logic                         fifo_full,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         fifo_wr,
  output logic [NUM_BITS-1:0]          fifo_data_in,
  output logic [1:0]                   grant_id
);

  logic [1:0] last_winner_q, last_winner_d;
  logic [1:0] rr_base;
  logic [1:0] rr_win;
  logic [1:0] win;
  logic       xfer;

`ifdef ARB_BURST_EN
  typedef enum logic [0:0] {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       owner_hold;

  assign owner_hold = (state_q == LOCK) && req[owner_q];
  // When the owner drops out, the others are searched starting after the owner.
  assign rr_base    = (state_q == LOCK) ? owner_q : last_winner_q;
`else
  assign rr_base    = last_winner_q;
`endif

  always_comb begin
    logic       found;
    logic [1:0] idx;
    found  = 1'b0;
    idx    = 2'd0;
    rr_win = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = 2'((int'(rr_base) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        rr_win = idx;
      end
    end
  end

  always_comb begin
    win = rr_win;
`ifdef ARB_BURST_EN
    if (owner_hold) win = owner_q;
`endif
    // Outputs are forced quiet while reset is held, independent of req.
    xfer          = rst && (|req) && !fifo_full;
    fifo_wr       = xfer;
    grant_id      = xfer ? win : 2'd0;
    ack           = '0;
    fifo_data_in  = '0;
    if (xfer) begin
      ack[win]     = 1'b1;
      fifo_data_in = req_data[int'(win)*NUM_BITS +: NUM_BITS];
    end
    last_winner_d = xfer ? win : last_winner_q;
  end

`ifdef ARB_BURST_EN
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (xfer) begin
      if (owner_hold) begin
        if (burst_cnt_q + 4'd1 == 4'(BURST_LEN)) begin
          state_d     = ARB;
          burst_cnt_d = 4'd0;
        end else begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end
      end else if (BURST_LEN > 1) begin
        state_d     = LOCK;
        owner_d     = win;
        burst_cnt_d = 4'd1;
      end else begin
        state_d     = ARB;
        burst_cnt_d = 4'd0;
      end
    end else if (!fifo_full && (state_q == LOCK) && !req[owner_q]) begin
      state_d     = ARB;
      burst_cnt_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB;
      owner_q     <= 2'd0;
      burst_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_winner_q <= 2'(NUM_REQ - 1);
    end else begin
      last_winner_q <= last_winner_d;
    end
  end

endmodule

`default_nettype wire
